// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side signal bundle for the hazard controller
interface hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] ex_rs1;
    logic [REG_AW-1:0] ex_rs2;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_mem_read;
    logic              ex_branch_taken;
    logic              ex_md_start;
    logic              md_done;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic              mem_reg_write;
    logic              wb_reg_write;

    logic              pc_en;
    logic              if_id_en;
    logic              id_ex_en;
    logic              ex_mem_en;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              ex_mem_flush;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              md_timeout;
    logic [1:0]        state;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_branch_taken, ex_md_start,
        output md_done, mem_rd, wb_rd, mem_reg_write, wb_reg_write,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en,
        input  if_id_flush, id_ex_flush, ex_mem_flush,
        input  fwd_a, fwd_b, md_timeout, state
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_mem_read, ex_branch_taken, ex_md_start,
        input  md_done, mem_rd, wb_rd, mem_reg_write, wb_reg_write,
        output pc_en, if_id_en, id_ex_en, ex_mem_en,
        output if_id_flush, id_ex_flush, ex_mem_flush,
        output fwd_a, fwd_b, md_timeout, state
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward controller for the 5-stage RV32 pipeline
// Optional performance counters are enabled with HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int REG_AW     = 5,
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    hazard_ctrl_if.slave     hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] md_cycles
`endif
);
    localparam int CW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MD_TIMEOUT - 1);
    localparam logic [REG_AW-1:0] X0 = '0;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        MD_WAIT = 2'b01,
        DRAIN   = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    logic       pc_en_c, if_id_en_c, id_ex_en_c, ex_mem_en_c;
    logic       if_id_flush_c, id_ex_flush_c, ex_mem_flush_c;
    logic [1:0] fwd_a_c, fwd_b_c;
    logic       load_use;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] mem_rd,
        input logic              mem_wr,
        input logic [REG_AW-1:0] wb_rd,
        input logic              wb_wr
    );
        if (mem_wr && mem_rd != X0 && mem_rd == rs)
            return 2'b10;
        else if (wb_wr && wb_rd != X0 && wb_rd == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign load_use = hz.ex_mem_read && (hz.ex_rd != X0) &&
                      ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
                       (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            RUN: begin
                if (!hz.ex_branch_taken && hz.ex_md_start) begin
                    state_d = MD_WAIT;
                    cnt_d   = '0;
                end
            end
            MD_WAIT: begin
                // md_done beats the watchdog when both land in the same cycle
                if (hz.md_done) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = DRAIN;
                    cnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DRAIN:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_en_c        = 1'b1;
        if_id_en_c     = 1'b1;
        id_ex_en_c     = 1'b1;
        ex_mem_en_c    = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_flush_c  = 1'b0;
        ex_mem_flush_c = 1'b0;
        fwd_a_c = fwd_sel(hz.ex_rs1, hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write);
        fwd_b_c = fwd_sel(hz.ex_rs2, hz.mem_rd, hz.mem_reg_write, hz.wb_rd, hz.wb_reg_write);
        if (reset) begin
            pc_en_c        = 1'b0;
            if_id_en_c     = 1'b0;
            id_ex_en_c     = 1'b0;
            ex_mem_en_c    = 1'b0;
            if_id_flush_c  = 1'b1;
            id_ex_flush_c  = 1'b1;
            ex_mem_flush_c = 1'b1;
            fwd_a_c        = 2'b00;
            fwd_b_c        = 2'b00;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz.ex_branch_taken) begin
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end else if (!hz.ex_md_start && load_use) begin
                        // hold PC and IF/ID, push one bubble into EX
                        pc_en_c       = 1'b0;
                        if_id_en_c    = 1'b0;
                        id_ex_flush_c = 1'b1;
                    end
                end
                MD_WAIT: begin
                    pc_en_c        = 1'b0;
                    if_id_en_c     = 1'b0;
                    id_ex_en_c     = 1'b0;
                    ex_mem_flush_c = 1'b1;
                end
                default: begin
                    pc_en_c    = 1'b0;
                    if_id_en_c = 1'b0;
                    id_ex_en_c = 1'b0;
                end
            endcase
        end
    end

    assign hz.pc_en        = pc_en_c;
    assign hz.if_id_en     = if_id_en_c;
    assign hz.id_ex_en     = id_ex_en_c;
    assign hz.ex_mem_en    = ex_mem_en_c;
    assign hz.if_id_flush  = if_id_flush_c;
    assign hz.id_ex_flush  = id_ex_flush_c;
    assign hz.ex_mem_flush = ex_mem_flush_c;
    assign hz.fwd_a        = fwd_a_c;
    assign hz.fwd_b        = fwd_b_c;
    assign hz.md_timeout   = timeout_q;
    assign hz.state        = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q, md_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
            md_q    <= '0;
        end else begin
            if (!pc_en_c && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
            if (state_q == RUN && hz.ex_branch_taken && flush_q != '1)
                flush_q <= flush_q + CNT_W'(1);
            if (state_q == MD_WAIT && md_q != '1)
                md_q <= md_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;
    assign md_cycles    = md_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
    localparam int TMO = 40;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5)) hz ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events, md_cycles;
    hazard_ctrl #(.REG_AW(5), .MD_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .hz(hz),
        .stall_cycles(stall_cycles), .flush_events(flush_events), .md_cycles(md_cycles)
    );
`else
    hazard_ctrl #(.REG_AW(5), .MD_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .hz(hz)
    );
`endif

    typedef struct {
        logic [4:0] id_rs1, id_rs2;
        logic       use1, use2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       mr, bt, mds, mdd;
        logic [4:0] mem_rd, wb_rd;
        logic       mw, ww;
    } in_t;

    typedef struct {
        in_t         in;
        logic [13:0] exp;
    } vec_t;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_flush, fwd_a, fwd_b, md_timeout, state}
    localparam logic [13:0] IDLE    = 14'b1111_000_00_00_0_00;
    localparam logic [13:0] IDLE_T  = 14'b1111_000_00_00_1_00;
    localparam logic [13:0] STALL   = 14'b0011_010_00_00_0_00;
    localparam logic [13:0] STALL_T = 14'b0011_010_00_00_1_00;
    localparam logic [13:0] WAIT0   = 14'b0001_001_00_00_0_01;
    localparam logic [13:0] WAIT_T  = 14'b0001_001_00_00_1_01;
    localparam logic [13:0] DRAIN0  = 14'b0001_000_00_00_0_10;
    localparam logic [13:0] DRAIN_T = 14'b0001_000_00_00_1_10;
    localparam logic [13:0] RST0    = 14'b0000_111_00_00_0_00;
    localparam logic [13:0] RST_WT  = 14'b0000_111_00_00_1_01;

    int vectors = 0;
    int miscompares = 0;
    logic [13:0] act;
    in_t cur;

    assign act = {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en,
                  hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush,
                  hz.fwd_a, hz.fwd_b, hz.md_timeout, hz.state};

    function automatic in_t zero_in();
        in_t v;
        v = '{default: '0};
        return v;
    endfunction

    function automatic in_t mk(input logic [4:0] r1, r2, input logic u1, u2,
                               input logic [4:0] e1, e2, erd, input logic mr, bt,
                               input logic [4:0] mrd, wrd, input logic mw, ww);
        in_t v;
        v = zero_in();
        v.id_rs1 = r1; v.id_rs2 = r2; v.use1 = u1; v.use2 = u2;
        v.ex_rs1 = e1; v.ex_rs2 = e2; v.ex_rd = erd; v.mr = mr; v.bt = bt;
        v.mem_rd = mrd; v.wb_rd = wrd; v.mw = mw; v.ww = ww;
        return v;
    endfunction

    task automatic apply(input in_t v);
        hz.id_rs1 = v.id_rs1;  hz.id_rs2 = v.id_rs2;
        hz.id_use_rs1 = v.use1; hz.id_use_rs2 = v.use2;
        hz.ex_rs1 = v.ex_rs1;  hz.ex_rs2 = v.ex_rs2;  hz.ex_rd = v.ex_rd;
        hz.ex_mem_read = v.mr; hz.ex_branch_taken = v.bt;
        hz.ex_md_start = v.mds; hz.md_done = v.mdd;
        hz.mem_rd = v.mem_rd;  hz.wb_rd = v.wb_rd;
        hz.mem_reg_write = v.mw; hz.wb_reg_write = v.ww;
    endtask

    task automatic step(input string nm, input logic [13:0] exp);
        @(negedge clk);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %b expected %b", nm, $time, act, exp);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input in_t v);
        if (v.mw && v.mem_rd != 0 && v.mem_rd == rs) return 2'b10;
        if (v.ww && v.wb_rd != 0 && v.wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // reference: mode 0 = running, 1 = waiting on mul/div, 2 = draining result
    int   m_mode, m_wait;
    logic m_to;

    function automatic logic [13:0] ref_out(input in_t v, input logic rst);
        logic [3:0] en;
        logic [2:0] fl;
        logic       lu;
        logic [1:0] fa, fb;
        lu = v.mr && v.ex_rd != 0 &&
             ((v.use1 && v.id_rs1 == v.ex_rd) || (v.use2 && v.id_rs2 == v.ex_rd));
        fa = ref_fwd(v.ex_rs1, v);
        fb = ref_fwd(v.ex_rs2, v);
        if (rst) begin
            en = 4'b0000; fl = 3'b111; fa = 2'b00; fb = 2'b00;
        end else if (m_mode == 1) begin
            en = 4'b0001; fl = 3'b001;
        end else if (m_mode == 2) begin
            en = 4'b0001; fl = 3'b000;
        end else if (v.bt) begin
            en = 4'b1111; fl = 3'b110;
        end else if (v.mds) begin
            en = 4'b1111; fl = 3'b000;
        end else if (lu) begin
            en = 4'b0011; fl = 3'b010;
        end else begin
            en = 4'b1111; fl = 3'b000;
        end
        return {en, fl, fa, fb, m_to, 2'(m_mode)};
    endfunction

    task automatic ref_advance(input in_t v, input logic rst);
        if (rst) begin
            m_mode = 0; m_wait = 0; m_to = 1'b0;
        end else if (m_mode == 0) begin
            if (!v.bt && v.mds) begin m_mode = 1; m_wait = 0; end
        end else if (m_mode == 1) begin
            if (v.mdd) m_mode = 2;
            else if (m_wait == TMO - 1) begin m_mode = 2; m_to = 1'b1; end
            else m_wait++;
        end else begin
            m_mode = 0;
        end
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{mk(0,0,0,0, 0,0,0, 0,0, 0,0,0,0), IDLE};
        tbl[1]  = '{mk(0,5,0,1, 0,0,5, 1,0, 0,0,0,0), STALL};
        tbl[2]  = '{mk(0,0,0,1, 0,0,0, 1,0, 0,0,0,0), IDLE};
        tbl[3]  = '{mk(0,5,0,0, 0,0,5, 1,0, 0,0,0,0), IDLE};
        tbl[4]  = '{mk(7,0,1,0, 0,0,7, 1,0, 0,0,0,0), STALL};
        tbl[5]  = '{mk(7,0,1,0, 0,0,7, 0,0, 0,0,0,0), IDLE};
        tbl[6]  = '{mk(0,5,0,1, 0,0,5, 1,1, 0,0,0,0), 14'b1111_110_00_00_0_00};
        tbl[7]  = '{mk(0,0,0,0, 3,0,0, 0,0, 3,3,1,1), 14'b1111_000_10_00_0_00};
        tbl[8]  = '{mk(0,0,0,0, 3,0,0, 0,0, 3,3,0,1), 14'b1111_000_01_00_0_00};
        tbl[9]  = '{mk(0,0,0,0, 0,0,0, 0,0, 0,0,1,1), IDLE};
        tbl[10] = '{mk(0,0,0,0, 0,4,0, 0,0, 6,4,1,1), 14'b1111_000_00_01_0_00};
        tbl[11] = '{mk(0,0,0,0, 9,9,0, 0,0, 9,9,1,1), 14'b1111_000_10_10_0_00};

        // reset held three cycles; forwarding is suppressed even with a match
        reset = 1'b1;
        cur = mk(0,0,0,0, 3,3,0, 0,0, 3,3,1,1);
        apply(cur);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) step("reset_hold", RST0);
        reset = 1'b0;
        cur = zero_in(); apply(cur);
        step("reset_release", IDLE);

        // mul/div finishing after 7 wait cycles; branch/start during wait are ignored
        cur = zero_in(); cur.mds = 1'b1; apply(cur);
        step("md_start", IDLE);
        for (int i = 1; i <= 7; i++) begin
            cur = zero_in();
            cur.mdd = (i == 7); cur.bt = (i == 3); cur.mds = (i == 2);
            apply(cur);
            step("md_wait", WAIT0);
        end
        cur = zero_in(); apply(cur);
        step("md_drain", DRAIN0);
        step("md_back_run", IDLE);

        // md_done on the watchdog's last cycle wins
        cur = zero_in(); cur.mds = 1'b1; apply(cur);
        step("md_start_b", IDLE);
        for (int i = 0; i < TMO; i++) begin
            cur = zero_in(); cur.mdd = (i == TMO - 1); apply(cur);
            step("md_wait_b", WAIT0);
        end
        cur = zero_in(); apply(cur);
        step("md_drain_b", DRAIN0);
        step("md_run_b", IDLE);

        // no md_done: watchdog fires and stays set
        cur = zero_in(); cur.mds = 1'b1; apply(cur);
        step("tmo_start", IDLE);
        cur = zero_in(); apply(cur);
        for (int i = 0; i < TMO; i++) step("tmo_wait", WAIT0);
        step("tmo_drain", DRAIN_T);
        step("tmo_run", IDLE_T);
        cur = mk(0,5,0,1, 0,0,5, 1,0, 0,0,0,0); apply(cur);
        step("tmo_sticky_stall", STALL_T);

        // reset in the middle of a wait abandons it and clears the flag
        cur = zero_in(); cur.mds = 1'b1; apply(cur);
        step("rst_mid_start", IDLE_T);
        cur = zero_in(); apply(cur);
        step("rst_mid_wait", WAIT_T);
        step("rst_mid_wait", WAIT_T);
        reset = 1'b1;
        step("rst_mid_assert", RST_WT);
        reset = 1'b0;
        step("rst_mid_release", IDLE);

        for (int i = 0; i < 12; i++) begin
            apply(tbl[i].in);
            step($sformatf("table_%0d", i), tbl[i].exp);
        end

        m_mode = 0; m_wait = 0; m_to = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic       rst;
            logic [13:0] e;
            cur.id_rs1 = 5'($urandom_range(0, 3));
            cur.id_rs2 = 5'($urandom_range(0, 3));
            cur.use1   = 1'($urandom);
            cur.use2   = 1'($urandom);
            cur.ex_rs1 = 5'($urandom_range(0, 3));
            cur.ex_rs2 = 5'($urandom_range(0, 3));
            cur.ex_rd  = 5'($urandom_range(0, 3));
            cur.mr     = 1'($urandom);
            cur.bt     = ($urandom_range(0, 7) == 0);
            cur.mds    = ($urandom_range(0, 7) == 0);
            cur.mdd    = ($urandom_range(0, 14) == 0);
            cur.mem_rd = 5'($urandom_range(0, 3));
            cur.wb_rd  = 5'($urandom_range(0, 3));
            cur.mw     = 1'($urandom);
            cur.ww     = 1'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            reset = rst;
            apply(cur);
            e = ref_out(cur, rst);
            step("random", e);
            ref_advance(cur, rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central stall/flush/forward controller for the 5-stage RV32 pipeline. It drives the enable and flush controls of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC. It sequences three hazard types: load-use stalls, taken-branch flushes, and multi-cycle mul/div waits. It also produces the EX-stage operand forwarding selects.

Parameters:
REG_AW, 5, register-index width
MD_TIMEOUT, 40, maximum cycles in MD_WAIT before the watchdog fires
CNT_W, 32, width of the performance counters (used only with the optional feature)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID
id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
ex_rs1, ex_rs2  in  REG_AW  source registers of the instruction in EX
ex_rd  in  REG_AW  destination register in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  branch/jump resolved taken in EX
ex_md_start  in  1  EX instruction starts a mul/div (1-cycle pulse)
md_done  in  1  mul/div result valid (1-cycle pulse)
mem_rd, wb_rd  in  REG_AW  destination registers in MEM and WB
mem_reg_write, wb_reg_write  in  1  MEM/WB stage writes the register file
pc_en, if_id_en, id_ex_en, ex_mem_en  out  1  register load enables
if_id_flush, id_ex_flush, ex_mem_flush  out  1  load a bubble (all zeros) on the next edge
fwd_a, fwd_b  out  2  EX operand select: 00 = register file, 10 = MEM, 01 = WB
md_timeout  out  1  sticky watchdog flag
state  out  2  00 = RUN, 01 = MD_WAIT, 10 = DRAIN

Behaviour:
- Reset, with reset high at an edge: state = RUN, wait counter = 0, md_timeout = 0.
- While reset is high: all *_en = 0, all *_flush = 1, fwd_a = fwd_b = 00.
- Control outputs are combinational from state plus inputs, giving zero-cycle latency to the pipeline registers.
- RUN, checked in priority order:
  1. ex_branch_taken: if_id_flush = id_ex_flush = 1; all enables = 1. Two bubbles. Stay in RUN. Any simultaneous load-use hazard is ignored.
  2. ex_md_start: next state = MD_WAIT; this cycle all enables = 1 and no flushes.
  3. Load-use hazard: ex_mem_read && ex_rd != 0 && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)). Then pc_en = if_id_en = 0 and id_ex_flush = 1 for exactly one cycle; ex_mem_en = 1. Stay in RUN.
  4. Otherwise: all enables = 1 and no flushes.
- MD_WAIT:
  - pc_en = if_id_en = id_ex_en = 0; ex_mem_en = 1 with ex_mem_flush = 1, so bubbles enter MEM.
  - The wait counter increments each cycle.
  - md_done: next state = DRAIN; counter cleared.
  - Counter reaches MD_TIMEOUT-1 with no md_done: set md_timeout (sticky until reset); next state = DRAIN.
  - md_done and timeout in the same cycle: md_done wins and md_timeout is not set.
- DRAIN: one cycle. ex_mem_en = 1, ex_mem_flush = 0 (the result is captured); pc_en = if_id_en = id_ex_en = 0. Next state = RUN.
- ex_branch_taken or ex_md_start while not in RUN is ignored.
- Forwarding, evaluated every cycle:
  - fwd_a = 10 if mem_reg_write && mem_rd != 0 && mem_rd == ex_rs1.
  - Else 01 if wb_reg_write && wb_rd != 0 && wb_rd == ex_rs1.
  - Else 00.
  - fwd_b is identical using ex_rs2. MEM takes priority over WB. x0 is never forwarded.
- Reset asserted mid-MD_WAIT: abandon the wait, state = RUN, counter = 0.
- Counter width is clog2(MD_TIMEOUT); the counter never wraps.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs stall_cycles, flush_events, md_cycles, each CNT_W bits and each reset to 0 on reset.
  - stall_cycles increments on each cycle with pc_en = 0 while reset is low.
  - flush_events increments once per taken-branch flush.
  - md_cycles increments each cycle in MD_WAIT.
  - All three saturate at all ones.
- Undefined: these ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset held 3 cycles, then released → during reset all en = 0 and all flush = 1; the first cycle after release has all en = 1, state = 00, md_timeout = 0.
- Load-use: ex_mem_read = 1, ex_rd = 5, id_rs2 = 5, id_use_rs2 = 1 → one cycle with pc_en = 0, if_id_en = 0, id_ex_flush = 1. Repeat with ex_rd = 0 → no stall.
- Branch and load-use in the same cycle → if_id_flush = id_ex_flush = 1, pc_en = 1, no stall.
- ex_md_start, then md_done 7 cycles later → state 01 for 7 cycles with ex_mem_flush = 1, then one cycle of DRAIN (10), then RUN. pc_en stays 0 for 8 cycles. md_timeout = 0.
- ex_md_start with no md_done → after 40 cycles md_timeout = 1, DRAIN, then RUN; md_timeout remains 1 until reset.
- Forwarding: mem_rd = wb_rd = 3, both reg_write = 1, ex_rs1 = 3 → fwd_a = 10. With mem_reg_write = 0 → 01. With ex_rs1 = 0 → 00.
